// File: rtl/picobello_pkg.sv
`default_nettype none
// ============================================================================
// Module      : picobello_pkg
// Description : Shared constants and types for the HWPE control demux.
// Revision    : 1.0 - initial release
// ============================================================================
package picobello_pkg;

    // Read data returned for requests that decode to no target
    localparam logic [31:0] HwpeCtrlErrData = 32'hBADCAB1E;

    // Default position of the target-select address field
    localparam int unsigned HwpeCtrlSelLsb  = 8;

    // Widest event vector a local read can return (NrCores <= 32)
    localparam int unsigned HwpeEvtMaxW     = 32;

    typedef logic [HwpeEvtMaxW-1:0] hwpe_evt_t;

    // Select field must encode every target plus the local event register
    function automatic int unsigned hwpe_sel_width(input int unsigned num_hwpe);
        return $clog2(num_hwpe + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_evt_aggr.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_evt_aggr
// Description : Merges per-HWPE event pulses into per-core interrupts.
//               HWPE_CTRL_EVT_STICKY_EN selects sticky W1C pending bits.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_evt_aggr #(
    parameter int unsigned NUM_HWPE = 2,
    parameter int unsigned NR_CORES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_HWPE*NR_CORES-1:0] i_evt,
    input  logic                         i_clr_en,
    input  logic [NR_CORES-1:0]          i_clr_mask,
    output logic [NR_CORES-1:0]          o_pending,
    output logic [NR_CORES-1:0]          o_irq
);

    logic [NR_CORES-1:0] w_evt_any;

    always_comb begin
        w_evt_any = '0;
        for (int h = 0; h < NUM_HWPE; h++) begin
            w_evt_any = w_evt_any | i_evt[h*NR_CORES +: NR_CORES];
        end
    end

`ifdef HWPE_CTRL_EVT_STICKY_EN
    logic [NR_CORES-1:0] r_pending;
    logic [NR_CORES-1:0] w_clr;

    assign w_clr = i_clr_en ? i_clr_mask : '0;

    // A new event takes priority over a clear landing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_evt_any;
        end
    end

    assign o_pending = r_pending;
    assign o_irq     = r_pending;
`else
    logic w_unused;
    assign w_unused  = ^{clk, rst, i_clr_en, i_clr_mask};

    assign o_pending = '0;
    assign o_irq     = w_evt_any;
`endif

endmodule
`default_nettype wire

// File: rtl/hwpe_ctrl_demux.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl_demux
// Description : Routes control requests to HWPE targets or a local event
//               register; HWPE_CTRL_EVT_STICKY_EN enables sticky events.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_demux
    import picobello_pkg::*;
#(
    parameter int unsigned NumHwpe        = 2,
    parameter int unsigned NrCores        = 8,
    parameter int unsigned SelLsb         = HwpeCtrlSelLsb,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       q_valid_i,
    output logic                       q_ready_o,
    input  logic [31:0]                q_addr_i,
    input  logic                       q_write_i,
    input  logic [31:0]                q_data_i,
    input  logic [3:0]                 q_strb_i,
    output logic                       p_valid_o,
    output logic [31:0]                p_data_o,
    output logic                       p_err_o,
    output logic [NumHwpe-1:0]         tgt_q_valid_o,
    input  logic [NumHwpe-1:0]         tgt_q_ready_i,
    output logic [31:0]                tgt_q_addr_o,
    output logic [31:0]                tgt_q_data_o,
    output logic [3:0]                 tgt_q_strb_o,
    output logic                       tgt_q_write_o,
    input  logic [NumHwpe-1:0]         tgt_p_valid_i,
    input  logic [NumHwpe*32-1:0]      tgt_p_data_i,
    input  logic [NumHwpe*NrCores-1:0] tgt_evt_i,
    output logic [NrCores-1:0]         mxip_o
);

    localparam int unsigned        c_sel_w     = hwpe_sel_width(NumHwpe);
    localparam int unsigned        c_cnt_w     = $clog2(MaxOutstanding + 1);
    localparam logic [c_sel_w-1:0] c_sel_local = c_sel_w'(NumHwpe);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(MaxOutstanding);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_sel_w-1:0] r_cur;
    logic               r_loc_valid;
    logic               r_loc_err;
    logic [31:0]        r_loc_data;

    logic [c_sel_w-1:0] w_sel;
    logic               w_sel_tgt, w_sel_local, w_cur_tgt;
    logic               w_cnt_zero, w_stall, w_q_ready, w_accept, w_resp;
    logic [NumHwpe-1:0] w_sel_tvalid;
    logic               w_sel_tready, w_cur_pvalid;
    logic [31:0]        w_cur_pdata, w_loc_data;
    logic               w_clr_en;
    logic [NrCores-1:0] w_clr_mask, w_pending, w_irq;
    hwpe_evt_t          w_rd_data;

    assign w_sel       = q_addr_i[SelLsb +: c_sel_w];
    assign w_sel_tgt   = (w_sel < c_sel_local);
    assign w_sel_local = (w_sel == c_sel_local);
    assign w_cur_tgt   = (r_cur < c_sel_local);
    assign w_cnt_zero  = (r_cnt == '0);

    always_comb begin
        w_sel_tvalid = '0;
        w_sel_tready = 1'b0;
        w_cur_pvalid = 1'b0;
        w_cur_pdata  = '0;
        for (int h = 0; h < NumHwpe; h++) begin
            if (w_sel == c_sel_w'(h)) begin
                w_sel_tvalid[h] = q_valid_i;
                w_sel_tready    = tgt_q_ready_i[h];
            end
            if (r_cur == c_sel_w'(h)) begin
                w_cur_pvalid = tgt_p_valid_i[h];
                w_cur_pdata  = tgt_p_data_i[h*32 +: 32];
            end
        end
    end

    // Local/error responses occupy a slot too, so anything but a same-target
    // follow-up waits until the pipe is empty.
    assign w_stall   = (r_cnt == c_cnt_max) ||
                       (!w_cnt_zero && (!w_sel_tgt || (w_sel != r_cur)));
    assign w_q_ready = !rst_i && !w_stall && (w_sel_tgt ? w_sel_tready : 1'b1);
    assign w_accept  = q_valid_i && w_q_ready;
    assign w_resp    = r_loc_valid || (!w_cnt_zero && w_cur_tgt && w_cur_pvalid);

    assign q_ready_o     = w_q_ready;
    assign tgt_q_valid_o = (rst_i || w_stall) ? '0 : w_sel_tvalid;
    assign tgt_q_addr_o  = q_addr_i;
    assign tgt_q_data_o  = q_data_i;
    assign tgt_q_strb_o  = q_strb_i;
    assign tgt_q_write_o = q_write_i;

    assign p_valid_o = !rst_i && w_resp;
    assign p_data_o  = r_loc_valid ? r_loc_data : w_cur_pdata;
    assign p_err_o   = r_loc_valid && r_loc_err;

    assign w_rd_data = hwpe_evt_t'(w_pending);
    assign w_clr_en  = w_accept && w_sel_local && q_write_i;

    always_comb begin
        w_clr_mask = '0;
        for (int c = 0; c < NrCores; c++) begin
            w_clr_mask[c] = q_data_i[c] & q_strb_i[c/8];
        end
    end

    always_comb begin
        w_loc_data = '0;
        if (!w_sel_local) begin
            w_loc_data = HwpeCtrlErrData;
        end else if (!q_write_i) begin
            w_loc_data = w_rd_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_cur       <= '0;
            r_loc_valid <= 1'b0;
            r_loc_err   <= 1'b0;
            r_loc_data  <= '0;
        end else begin
            if (w_accept && !w_resp) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_accept && w_resp) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_accept) begin
                r_cur <= w_sel;
            end
            r_loc_valid <= w_accept && !w_sel_tgt;
            r_loc_err   <= w_accept && !w_sel_tgt && !w_sel_local;
            r_loc_data  <= (w_accept && !w_sel_tgt) ? w_loc_data : '0;
        end
    end

    hwpe_evt_aggr #(
        .NUM_HWPE (NumHwpe),
        .NR_CORES (NrCores)
    ) u_evt_aggr (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_evt      (tgt_evt_i),
        .i_clr_en   (w_clr_en),
        .i_clr_mask (w_clr_mask),
        .o_pending  (w_pending),
        .o_irq      (w_irq)
    );

    assign mxip_o = rst_i ? '0 : w_irq;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_ctrl_demux
// Description : Directed and randomized self-checking bench for hwpe_ctrl_demux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_ctrl_demux;

    localparam int unsigned NumHwpe = 2;
    localparam int unsigned NrCores = 8;
    localparam int unsigned SelLsb  = 8;
    localparam int unsigned SelW    = 2;
    localparam int unsigned MaxOut  = 4;

    logic                       clk = 1'b0;
    logic                       rst_i;
    logic                       q_valid_i, q_ready_o, q_write_i;
    logic [31:0]                q_addr_i, q_data_i;
    logic [3:0]                 q_strb_i;
    logic                       p_valid_o, p_err_o;
    logic [31:0]                p_data_o;
    logic [NumHwpe-1:0]         tgt_q_valid_o, tgt_q_ready_i, tgt_p_valid_i;
    logic [31:0]                tgt_q_addr_o, tgt_q_data_o;
    logic [3:0]                 tgt_q_strb_o;
    logic                       tgt_q_write_o;
    logic [NumHwpe*32-1:0]      tgt_p_data_i;
    logic [NumHwpe*NrCores-1:0] tgt_evt_i;
    logic [NrCores-1:0]         mxip_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: targets of in-flight requests, pending local reply
    int unsigned flight[$];
    int unsigned m_cur = 0;
    bit          m_loc_due = 1'b0;
    bit          m_loc_err = 1'b0;
    logic [31:0] m_loc_data = '0;

`ifdef HWPE_CTRL_EVT_STICKY_EN
    localparam bit Sticky = 1'b1;
`else
    localparam bit Sticky = 1'b0;
`endif

    always #5 clk = ~clk;

    hwpe_ctrl_demux #(
        .NumHwpe        (NumHwpe),
        .NrCores        (NrCores),
        .SelLsb         (SelLsb),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .q_valid_i     (q_valid_i),
        .q_ready_o     (q_ready_o),
        .q_addr_i      (q_addr_i),
        .q_write_i     (q_write_i),
        .q_data_i      (q_data_i),
        .q_strb_i      (q_strb_i),
        .p_valid_o     (p_valid_o),
        .p_data_o      (p_data_o),
        .p_err_o       (p_err_o),
        .tgt_q_valid_o (tgt_q_valid_o),
        .tgt_q_ready_i (tgt_q_ready_i),
        .tgt_q_addr_o  (tgt_q_addr_o),
        .tgt_q_data_o  (tgt_q_data_o),
        .tgt_q_strb_o  (tgt_q_strb_o),
        .tgt_q_write_o (tgt_q_write_o),
        .tgt_p_valid_i (tgt_p_valid_i),
        .tgt_p_data_i  (tgt_p_data_i),
        .tgt_evt_i     (tgt_evt_i),
        .mxip_o        (mxip_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        q_valid_i     = 1'b0;
        tgt_p_valid_i = '0;
        tgt_evt_i     = '0;
    endtask

    task automatic req(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                       input logic [3:0] strb);
        q_valid_i = 1'b1;
        q_addr_i  = addr;
        q_write_i = wr;
        q_data_i  = data;
        q_strb_i  = strb;
    endtask

    // One cycle of random traffic checked against the queue-based model
    task automatic rand_cycle(input bit drain);
        int unsigned     sel;
        bit              is_tgt, busy, stall, exp_ready, resp_tgt, exp_pvalid, acc;
        logic [NumHwpe-1:0] exp_tvalid;
        logic [31:0]     addr, exp_pdata;
        sel  = drain ? 0 : $urandom_range(0, 3);
        addr = $urandom;
        addr[SelLsb +: SelW] = sel[SelW-1:0];
        q_valid_i     = drain ? 1'b0 : 1'($urandom_range(0, 1));
        q_addr_i      = addr;
        q_write_i     = 1'($urandom);
        q_data_i      = $urandom;
        q_strb_i      = 4'($urandom);
        tgt_q_ready_i = 2'($urandom);
        tgt_p_data_i  = {$urandom, $urandom};
        tgt_evt_i     = '0;
        if (drain) tgt_p_valid_i = (flight.size() > 0) ? 2'(1 << m_cur) : 2'b00;
        else for (int h = 0; h < NumHwpe; h++) tgt_p_valid_i[h] = ($urandom_range(0, 3) == 0);
        #1;
        is_tgt     = (sel < NumHwpe);
        busy       = (flight.size() > 0) || m_loc_due;
        stall      = (flight.size() == MaxOut) ||
                     (busy && !(is_tgt && flight.size() > 0 && sel == m_cur));
        exp_ready  = !stall && (is_tgt ? tgt_q_ready_i[sel] : 1'b1);
        exp_tvalid = (!stall && is_tgt && q_valid_i) ? 2'(1 << sel) : 2'b00;
        resp_tgt   = (flight.size() > 0) && tgt_p_valid_i[m_cur];
        exp_pvalid = m_loc_due || resp_tgt;
        exp_pdata  = m_loc_due ? m_loc_data : tgt_p_data_i[m_cur*32 +: 32];
        check("rnd_q_ready", q_ready_o, exp_ready);
        check("rnd_tgt_valid", tgt_q_valid_o, exp_tvalid);
        check("rnd_p_valid", p_valid_o, exp_pvalid);
        check("rnd_mxip", mxip_o, 0);
        if (exp_pvalid) begin
            check("rnd_p_data", p_data_o, exp_pdata);
            check("rnd_p_err", p_err_o, m_loc_due && m_loc_err);
        end
        acc = q_valid_i && exp_ready;
        if (resp_tgt) flight.delete(0);
        m_loc_due = acc && !is_tgt;
        if (acc && !is_tgt) begin
            m_loc_err  = (sel > NumHwpe);
            m_loc_data = m_loc_err ? 32'hBADCAB1E : 32'h0;
        end
        if (acc && is_tgt) begin
            flight.push_back(sel);
            m_cur = sel;
        end
        cyc();
    endtask

    initial begin
        // Reset: outputs forced low even with every input asserted
        rst_i = 1'b1;
        req(32'h0, 1'b0, 32'h0, 4'hF);
        tgt_q_ready_i = '1;
        tgt_p_valid_i = '1;
        tgt_p_data_i  = '0;
        tgt_evt_i     = '1;
        #1;
        check("rst_q_ready", q_ready_o, 0);
        check("rst_tgt_valid", tgt_q_valid_o, 0);
        check("rst_p_valid", p_valid_o, 0);
        check("rst_mxip", mxip_o, 0);
        cyc();
        cyc();
        rst_i = 1'b0;
        idle();
        cyc();

        // Single write to target 0 and its response
        req(32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        #1;
        check("wr_tgt_valid", tgt_q_valid_o, 2'b01);
        check("wr_q_ready", q_ready_o, 1);
        check("wr_bcast_data", tgt_q_data_o, 32'hDEAD_BEEF);
        check("wr_bcast_write", tgt_q_write_o, 1);
        cyc();
        req(32'h0000_0100, 1'b0, 32'h0, 4'hF);
        #1;
        check("sw_stall_ready", q_ready_o, 0);
        check("sw_stall_valid", tgt_q_valid_o, 0);
        tgt_p_valid_i = 2'b01;
        tgt_p_data_i  = {32'h1111_1111, 32'hCAFE_F00D};
        #1;
        check("wr_p_valid", p_valid_o, 1);
        check("wr_p_data", p_data_o, 32'hCAFE_F00D);
        check("wr_p_err", p_err_o, 0);
        check("wr_resp_stall", q_ready_o, 0);
        cyc();
        tgt_p_valid_i = '0;
        #1;
        check("sw_ready", q_ready_o, 1);
        check("sw_tgt_valid", tgt_q_valid_o, 2'b10);
        check("sw_p_valid", p_valid_o, 0);
        cyc();
        q_valid_i     = 1'b0;
        tgt_p_valid_i = 2'b10;
        tgt_p_data_i  = {32'h1234_5678, 32'h0};
        #1;
        check("t1_p_data", p_data_o, 32'h1234_5678);
        cyc();
        idle();

        // Four outstanding reads to target 0, then a switch to target 1
        for (int i = 0; i < 4; i++) begin
            req(32'h0000_0000, 1'b0, 32'h0, 4'hF);
            #1;
            check("fill_ready", q_ready_o, 1);
            cyc();
        end
        #1;
        check("full_ready", q_ready_o, 0);
        check("full_valid", tgt_q_valid_o, 0);
        req(32'h0000_0100, 1'b0, 32'h0, 4'hF);
        for (int r = 0; r < 4; r++) begin
            tgt_p_valid_i = 2'b01;
            #1;
            check("drain_stall", q_ready_o, 0);
            check("drain_p_valid", p_valid_o, 1);
            cyc();
        end
        tgt_p_valid_i = '0;
        #1;
        check("switch_ready", q_ready_o, 1);
        check("switch_valid", tgt_q_valid_o, 2'b10);
        cyc();
        q_valid_i     = 1'b0;
        tgt_p_valid_i = 2'b10;
        cyc();
        idle();

        // Decode error and local read
        req(32'h0000_0300, 1'b1, 32'hFFFF_FFFF, 4'hF);
        #1;
        check("err_ready", q_ready_o, 1);
        check("err_tgt_valid", tgt_q_valid_o, 0);
        cyc();
        q_valid_i = 1'b0;
        #1;
        check("err_p_valid", p_valid_o, 1);
        check("err_p_err", p_err_o, 1);
        check("err_p_data", p_data_o, 32'hBADCAB1E);
        cyc();
        check("err_p_done", p_valid_o, 0);
        req(32'h0000_0200, 1'b0, 32'h0, 4'hF);
        cyc();
        q_valid_i = 1'b0;
        #1;
        check("loc_p_valid", p_valid_o, 1);
        check("loc_p_err", p_err_o, 0);
        check("loc_p_data", p_data_o, 0);
        cyc();

        // Randomized traffic, then drain the model and the DUT together
        for (int i = 0; i < 400; i++) rand_cycle(1'b0);
        for (int i = 0; i < 8; i++) rand_cycle(1'b1);
        idle();
        tgt_q_ready_i = '1;

        // Event aggregation
        tgt_evt_i[NrCores +: NrCores] = 8'h04;
        #1;
        check("evt_pulse", mxip_o, Sticky ? 32'h0 : 32'h4);
        cyc();
        tgt_evt_i = '0;
        #1;
        check("evt_after", mxip_o, Sticky ? 32'h4 : 32'h0);
        cyc();
        check("evt_held", mxip_o, Sticky ? 32'h4 : 32'h0);
        req(32'h0000_0200, 1'b1, 32'h4, 4'h0);
        cyc();
        q_valid_i = 1'b0;
        #1;
        check("w1c_no_strb", mxip_o, Sticky ? 32'h4 : 32'h0);
        check("w1c_resp", p_valid_o, 1);
        cyc();
        req(32'h0000_0200, 1'b1, 32'h4, 4'h1);
        cyc();
        q_valid_i = 1'b0;
        #1;
        check("w1c_clear", mxip_o, 0);
        cyc();
        req(32'h0000_0200, 1'b1, 32'h4, 4'h1);
        tgt_evt_i[NrCores +: NrCores] = 8'h04;
        cyc();
        idle();
        #1;
        check("set_beats_clr", mxip_o, Sticky ? 32'h4 : 32'h0);
        cyc();
        req(32'h0000_0200, 1'b0, 32'h0, 4'hF);
        cyc();
        q_valid_i = 1'b0;
        #1;
        check("loc_rd_pending", p_data_o, Sticky ? 32'h4 : 32'h0);
        cyc();

        // Reset with two requests in flight
        req(32'h0000_0000, 1'b0, 32'h0, 4'hF);
        cyc();
        cyc();
        tgt_evt_i     = '1;
        tgt_p_valid_i = 2'b01;
        rst_i         = 1'b1;
        #1;
        check("mid_rst_ready", q_ready_o, 0);
        check("mid_rst_pvalid", p_valid_o, 0);
        check("mid_rst_tvalid", tgt_q_valid_o, 0);
        check("mid_rst_mxip", mxip_o, 0);
        cyc();
        cyc();
        rst_i     = 1'b0;
        q_valid_i = 1'b0;
        tgt_evt_i = '0;
        #1;
        check("late_resp", p_valid_o, 0);
        cyc();
        tgt_p_valid_i = '0;
        req(32'h0000_0000, 1'b0, 32'h0, 4'hF);
        #1;
        check("post_rst_ready", q_ready_o, 1);
        cyc();
        q_valid_i     = 1'b0;
        tgt_p_valid_i = 2'b01;
        #1;
        check("post_rst_resp", p_valid_o, 1);
        cyc();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwpe_ctrl_demux.md
HWPE_CTRL_DEMUX -- requirements
Module: hwpe_ctrl_demux

Interface
REQ-001 The block SHALL have parameter NumHwpe, default 2, meaning HWPE control targets (1..8).
REQ-002 The block SHALL have parameter NrCores, default 8, meaning event/interrupt width per target.
REQ-003 The block SHALL have parameter SelLsb, default 8, meaning the LSB of the target-select address field (width SelW = clog2(NumHwpe+1)).
REQ-004 The block SHALL have parameter MaxOutstanding, default 4, meaning in-flight requests allowed (power of 2, >=1).
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- q_valid_i  in  1  upstream request valid
- q_ready_o  out  1  upstream request accepted
- q_addr_i  in  32  address
- q_write_i  in  1  write
- q_data_i  in  32  write data
- q_strb_i  in  4  byte enables
- p_valid_o  out  1  response valid (one cycle, no back-pressure)
- p_data_o  out  32  read data
- p_err_o  out  1  decode error
- tgt_q_valid_o  out  NumHwpe  per-target request valid
- tgt_q_ready_i  in  NumHwpe  per-target ready
- tgt_q_addr_o / tgt_q_data_o / tgt_q_strb_o / tgt_q_write_o  out  32/32/4/1  broadcast request payload
- tgt_p_valid_i  in  NumHwpe  per-target response valid
- tgt_p_data_i  in  NumHwpe x 32  per-target read data
- tgt_evt_i  in  NumHwpe x NrCores  HWPE event pulses
- mxip_o  out  NrCores  per-core external interrupt

Function
REQ-006 The block SHALL compute sel = q_addr_i[SelLsb +: SelW]; sel < NumHwpe selects a target, sel == NumHwpe selects the local event register, and larger values are decode errors.
REQ-007 The block SHALL drive tgt_q_valid_o[sel] = q_valid_i when the request is not stalled; q_ready_o SHALL equal tgt_q_ready_i[sel] under the same condition.
REQ-008 The block SHALL stall (q_ready_o=0, no target valid) when the outstanding count equals MaxOutstanding, or when the count is nonzero and sel differs from the current target register.
REQ-009 On each accepted handshake, the block SHALL increment the outstanding count and load the current target register with sel; each response SHALL decrement the count; a simultaneous accept and response SHALL leave the count unchanged.
REQ-010 Target responses SHALL be forwarded combinationally: p_valid_o = tgt_p_valid_i[cur], p_data_o = tgt_p_data_i[cur], p_err_o = 0.
REQ-011 Local and error requests SHALL be accepted only when the count is 0; the response SHALL follow exactly 1 cycle later.
REQ-012 A local or error response SHALL NOT coincide with a target response.
REQ-013 A decode error SHALL respond with p_err_o=1 and p_data_o=32'hBADCAB1E; writes SHALL have no side effect.
REQ-014 A tgt_p_valid_i arriving while the count is 0 SHALL be ignored (assertion in simulation).

Reset
REQ-015 While rst_i=1, the block SHALL hold the outstanding count at 0, cur at 0, the event pending register at 0, and local response valid at 0.
REQ-016 While rst_i=1, q_ready_o, p_valid_o, tgt_q_valid_o and mxip_o SHALL be 0.
REQ-017 Reset asserted mid-transaction SHALL drop in-flight state; late target responses SHALL be ignored per REQ-014.

Configuration
REQ-018 With HWPE_CTRL_EVT_STICKY_EN defined, pending[c] SHALL set on any tgt_evt_i[h][c]=1 and mxip_o SHALL equal pending.
REQ-019 With HWPE_CTRL_EVT_STICKY_EN defined, a local read SHALL return pending zero-extended, and a local write SHALL clear pending bits where q_data_i=1 (W1C, per strb byte).
REQ-020 With HWPE_CTRL_EVT_STICKY_EN defined, a set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-021 Without HWPE_CTRL_EVT_STICKY_EN, mxip_o SHALL be the combinational OR over h of tgt_evt_i[h], local reads SHALL return 0, and local writes SHALL be ignored (no error).

Structure
REQ-022 HwpeCtrlErrData, the select-field constants and the hwpe_evt_t typedef SHALL live in picobello_pkg.
REQ-023 The block SHALL have one sub-module, hwpe_evt_aggr, containing the pending register, W1C logic and OR-reduction.

Verification
REQ-024 Write to a target: addr 0x000, sel=0, tgt_q_ready_i=1 -> tgt_q_valid_o=01; count 1; tgt_p_valid_i[0] -> p_valid_o, count 0.
REQ-025 Target switch: 4 reads to target 0 with responses pending, then 1 to target 1 -> 5th stalled until 4th response; also at count=4 -> q_ready_o=0.
REQ-026 Decode error: NumHwpe=2, addr 0x300 -> next cycle p_err_o=1, p_data_o=BADCAB1E.
REQ-027 Events (macro on): tgt_evt_i[1]=0x04 pulse -> mxip_o=0x04 held; write 0x04 to addr 0x200 -> mxip_o=0; simultaneous pulse and clear -> stays 0x04.
REQ-028 Reset mid-flight: count=2, assert rst_i -> all outputs 0; a late tgt_p_valid_i produces no p_valid_o.
